// File: rtl/tcu_agen_pkg.sv
// Shared types and sizing for the tensor-core tile address generator.
package tcu_agen_pkg;

   localparam int XLEN       = 32;
   localparam int WORD_BYTES = 4;
   localparam int MAX_DIM    = 16;
   localparam int DIM_W      = $clog2(MAX_DIM + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [XLEN-1:0]  base;
      logic [XLEN-1:0]  stride;
      logic [DIM_W-1:0] rows;
      logic [DIM_W-1:0] cols;
      logic             load;
   } tile_cmd_t;

endpackage

// File: rtl/tcu_tile_counter.sv
// Row/column position tracker for one tile walk; flags the last column and last beat.
module tcu_tile_counter
   import tcu_agen_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             advance,
   input  logic [DIM_W-1:0] rows,
   input  logic [DIM_W-1:0] cols,
   output logic             last_col,
   output logic             last_tile,
   output logic             row_advance
);

   logic [DIM_W-1:0] row_q, row_d;
   logic [DIM_W-1:0] col_q, col_d;

   assign last_col    = (col_q == cols - DIM_W'(1));
   assign last_tile   = last_col && (row_q == rows - DIM_W'(1));
   assign row_advance = advance && last_col && !last_tile;

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clear) begin
         row_d = '0;
         col_d = '0;
      end else if (advance) begin
         if (last_col) begin
            col_d = '0;
            row_d = last_tile ? '0 : row_q + DIM_W'(1);
         end else begin
            col_d = col_q + DIM_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

endmodule

// File: rtl/tcu_tile_agen.sv
// Tile address generator: walks a tile row-major and issues one word request per beat.
// Optional stall counter output enabled by defining TCU_AGEN_PERF_EN.
//
// state | meaning
// IDLE  | waiting for a tile command, cmd_ready high
// RUN   | issuing word requests toward the LSU
// DONE  | one-cycle completion pulse, then back to IDLE
module tcu_tile_agen
   import tcu_agen_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [XLEN-1:0]  cmd_base,
   input  logic [XLEN-1:0]  cmd_stride,
   input  logic [DIM_W-1:0] cmd_rows,
   input  logic [DIM_W-1:0] cmd_cols,
   input  logic             cmd_load,
   output logic             req_valid,
   input  logic             req_ready,
   output logic [XLEN-1:0]  req_addr,
   output logic             req_load,
   output logic             req_last,
   output logic             busy,
   output logic             done
`ifdef TCU_AGEN_PERF_EN
   ,
   output logic [31:0]      stall_cycles
`endif
);

   localparam logic [DIM_W-1:0] MAX_DIM_V = DIM_W'(MAX_DIM);

   state_t          state_q, state_d;
   tile_cmd_t       cmd_q, cmd_d;
   logic [XLEN-1:0] cur_addr_q, cur_addr_d;
   logic            accept;
   logic            hs;
   logic            last_col;
   logic            last_tile;
   logic            row_advance;

   assign accept = (state_q == IDLE) && cmd_valid;
   assign hs     = (state_q == RUN) && req_ready;

   tcu_tile_counter u_counter (
      .clk         (clk),
      .reset_n     (reset_n),
      .clear       (accept),
      .advance     (hs),
      .rows        (cmd_q.rows),
      .cols        (cmd_q.cols),
      .last_col    (last_col),
      .last_tile   (last_tile),
      .row_advance (row_advance)
   );

   // cmd_q.base doubles as the running row base once the walk starts.
   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      cur_addr_d = cur_addr_q;
      cmd_ready  = 1'b0;
      req_valid  = 1'b0;
      done       = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (accept) begin
               cmd_d      = '{base: cmd_base, stride: cmd_stride, rows: cmd_rows,
                              cols: cmd_cols, load: cmd_load};
               cur_addr_d = cmd_base;
               state_d    = (cmd_rows == '0 || cmd_cols == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            req_valid = 1'b1;
            if (hs) begin
               if (last_tile) begin
                  state_d = DONE;
               end else if (row_advance) begin
                  cmd_d.base = cmd_q.base + cmd_q.stride;
                  cur_addr_d = cmd_q.base + cmd_q.stride;
               end else begin
                  cur_addr_d = cur_addr_q + XLEN'(WORD_BYTES);
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cmd_q      <= '0;
         cur_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         cur_addr_q <= cur_addr_d;
      end
   end

   assign req_addr = cur_addr_q;
   assign req_load = cmd_q.load;
   assign req_last = (state_q == RUN) && last_tile;
   assign busy     = (state_q != IDLE);

`ifdef TCU_AGEN_PERF_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (accept) begin
         stall_d = '0;
      end else if (req_valid && !req_ready && stall_q != '1) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;
`endif

   a_dim_range: assert property (@(posedge clk) disable iff (!reset_n)
      accept |-> (cmd_rows <= MAX_DIM_V && cmd_cols <= MAX_DIM_V));

   a_row_adv: assert property (@(posedge clk) disable iff (!reset_n)
      row_advance |-> last_col);

endmodule

// File: tb/tb_tcu_tile_agen.sv
// Self-checking bench for tcu_tile_agen: directed table, reset abort, randomized tiles vs. model.
module tb_tcu_tile_agen;
   import tcu_agen_pkg::*;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [XLEN-1:0]  cmd_base;
   logic [XLEN-1:0]  cmd_stride;
   logic [DIM_W-1:0] cmd_rows;
   logic [DIM_W-1:0] cmd_cols;
   logic             cmd_load;
   logic             req_valid;
   logic             req_ready;
   logic [XLEN-1:0]  req_addr;
   logic             req_load;
   logic             req_last;
   logic             busy;
   logic             done;
`ifdef TCU_AGEN_PERF_EN
   logic [31:0]      stall_cycles;
`endif

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   tcu_tile_agen dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_base   (cmd_base),
      .cmd_stride (cmd_stride),
      .cmd_rows   (cmd_rows),
      .cmd_cols   (cmd_cols),
      .cmd_load   (cmd_load),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_load   (req_load),
      .req_last   (req_last),
      .busy       (busy),
      .done       (done)
`ifdef TCU_AGEN_PERF_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   typedef struct {
      logic [31:0] base;
      logic [31:0] stride;
      int          rows;
      int          cols;
      logic        load;
      int          stall_beat;
      int          stall_len;
      bit          spam;
      int          exp_beats;
      logic [31:0] exp_first;
      logic [31:0] exp_lastaddr;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] base, input logic [31:0] stride,
                               input int rows, input int cols, input logic load,
                               input int sb, input int sl, input bit spam,
                               input int eb, input logic [31:0] ef, input logic [31:0] el);
      vec_t v;
      v.base = base; v.stride = stride; v.rows = rows; v.cols = cols; v.load = load;
      v.stall_beat = sb; v.stall_len = sl; v.spam = spam;
      v.exp_beats = eb; v.exp_first = ef; v.exp_lastaddr = el;
      return v;
   endfunction

   // Entered and left on a falling edge with the DUT idle.
   task automatic run_tile(input vec_t v, input int stall_pct);
      logic [31:0] exp_q[$];
      int          n, idx, budget, stalls, stall_done;
      logic        rdy;
      logic [31:0] first_seen, last_seen;
      exp_q.delete();
      for (int r = 0; r < v.rows; r++)
         for (int c = 0; c < v.cols; c++)
            exp_q.push_back(v.base + 32'(r) * v.stride + 32'(c * WORD_BYTES));
      n = v.rows * v.cols;
      first_seen = '0;
      last_seen  = '0;

      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid  = 1'b1;
      cmd_base   = v.base;
      cmd_stride = v.stride;
      cmd_rows   = DIM_W'(v.rows);
      cmd_cols   = DIM_W'(v.cols);
      cmd_load   = v.load;
      req_ready  = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
`ifdef TCU_AGEN_PERF_EN
      chk("stall_clear_on_accept", stall_cycles, 0);
`endif
      if (n == 0) begin
         chk("empty_done", done, 1);
         chk("empty_req_valid", req_valid, 0);
         chk("empty_busy", busy, 1);
         chk("empty_cmd_ready", cmd_ready, 0);
         @(negedge clk);
         chk("empty_done_off", done, 0);
         chk("empty_cmd_ready_back", cmd_ready, 1);
         chk("empty_busy_off", busy, 0);
         if (v.exp_beats >= 0) chk("beats", 0, v.exp_beats);
         return;
      end

      idx = 0; budget = 0; stalls = 0; stall_done = 0;
      while (idx < n && budget < 4000) begin
         chk("req_valid", req_valid, 1);
         chk("req_addr", req_addr, exp_q[idx]);
         chk("req_last", req_last, (idx == n - 1));
         chk("req_load", req_load, v.load);
         chk("cmd_ready_run", cmd_ready, 0);
         chk("done_run", done, 0);
         if (idx == 0) first_seen = req_addr;
         last_seen = req_addr;
         if (idx == v.stall_beat && stall_done < v.stall_len) begin
            rdy = 1'b0;
            stall_done++;
         end else if (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
            rdy = 1'b0;
         end else begin
            rdy = 1'b1;
         end
         if (!rdy) stalls++;
         req_ready = rdy;
         cmd_valid = v.spam;
         if (v.spam) begin
            cmd_base = 32'hDEAD_0000;
            cmd_rows = DIM_W'(1);
            cmd_cols = DIM_W'(1);
            cmd_load = ~v.load;
         end
         @(negedge clk);
         budget++;
         if (rdy) idx++;
      end
      if (idx < n) begin
         n_cmp++;
         n_mis++;
         $display("FAIL tile_timeout: beats=%0d required=%0d", idx, n);
      end
      req_ready = 1'b0;
      cmd_valid = 1'b0;
      chk("done_pulse", done, 1);
      chk("done_req_valid", req_valid, 0);
      chk("done_busy", busy, 1);
      chk("done_cmd_ready", cmd_ready, 0);
`ifdef TCU_AGEN_PERF_EN
      chk("stall_cycles", stall_cycles, stalls);
`endif
      @(negedge clk);
      chk("done_off", done, 0);
      chk("cmd_ready_back", cmd_ready, 1);
      chk("busy_off", busy, 0);
      if (v.exp_beats >= 0) begin
         chk("beats", idx, v.exp_beats);
         chk("first_addr", first_seen, v.exp_first);
         chk("last_addr", last_seen, v.exp_lastaddr);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[9];
      vec_t rv;

      vecs[0] = mk(32'h1000, 32'h40, 2, 3, 1'b1, -1, 0, 1'b0, 6, 32'h1000, 32'h1048);
      vecs[1] = mk(32'h1000, 32'h40, 2, 3, 1'b1, 1, 3, 1'b0, 6, 32'h1000, 32'h1048);
      vecs[2] = mk(32'h1000, 32'h40, 0, 5, 1'b1, -1, 0, 1'b0, 0, 32'h0, 32'h0);
      vecs[3] = mk(32'hFFFF_FFFC, 32'h4, 2, 1, 1'b0, -1, 0, 1'b0, 2, 32'hFFFF_FFFC, 32'h0);
      vecs[4] = mk(32'h500, 32'h10, 3, 0, 1'b0, -1, 0, 1'b0, 0, 32'h0, 32'h0);
      vecs[5] = mk(32'h2000, 32'h100, 3, 4, 1'b1, 5, 2, 1'b1, 12, 32'h2000, 32'h220C);
      vecs[6] = mk(32'h80, 32'h0, 1, 1, 1'b0, -1, 0, 1'b0, 1, 32'h80, 32'h80);
      vecs[7] = mk(32'h0, 32'h40, 16, 16, 1'b1, -1, 0, 1'b0, 256, 32'h0, 32'h3FC);
      vecs[8] = mk(32'h1000, 32'h40, 2, 3, 1'b1, 2, 5, 1'b0, 6, 32'h1000, 32'h1048);

      reset_n    = 1'b0;
      cmd_valid  = 1'b0;
      cmd_base   = '0;
      cmd_stride = '0;
      cmd_rows   = '0;
      cmd_cols   = '0;
      cmd_load   = 1'b0;
      req_ready  = 1'b0;
      #12;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_req_valid", req_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_req_addr", req_addr, 0);
      chk("rst_req_last", req_last, 0);
      chk("rst_req_load", req_load, 0);
`ifdef TCU_AGEN_PERF_EN
      chk("rst_stall_cycles", stall_cycles, 0);
`endif
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 9; i++) run_tile(vecs[i], 0);

      // Reset during beat 3 aborts the walk with no done pulse.
      cmd_valid  = 1'b1;
      cmd_base   = 32'h1000;
      cmd_stride = 32'h40;
      cmd_rows   = DIM_W'(2);
      cmd_cols   = DIM_W'(3);
      cmd_load   = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      req_ready = 1'b1;
      chk("abort_beat1", req_addr, 32'h1000);
      @(negedge clk);
      chk("abort_beat2", req_addr, 32'h1004);
      @(negedge clk);
      chk("abort_beat3", req_addr, 32'h1008);
      reset_n = 1'b0;
      #1;
      chk("abort_req_valid", req_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_cmd_ready", cmd_ready, 1);
      chk("abort_req_load", req_load, 0);
      @(negedge clk);
      reset_n   = 1'b1;
      req_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abort_no_done", done, 0);
         chk("abort_idle", req_valid, 0);
      end

      for (int t = 0; t < 30; t++) begin
         rv = mk($urandom, 32'($urandom_range(0, 255)) << 2, $urandom_range(0, 16),
                 $urandom_range(0, 16), 1'($urandom_range(0, 1)), -1, 0,
                 bit'($urandom_range(0, 1)), -1, 32'h0, 32'h0);
         if (t % 5 == 0) rv.stride = $urandom;
         run_tile(rv, 30);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
